rx_lane_fifo_rr: RTL
====================

# rx_lane_fifo_rr

Receive-side buffering and merge stage that sits directly downstream of the 4-lane receive chain (after the 2x4 demux). It captures the four per-lane byte streams (`data_rx0..3` / `valid_rx0..3`) into independent small FIFOs. It then drains them into a single byte stream with a fair round-robin arbiter and a valid/ready output handshake. Per-lane full, empty and sticky overflow flags are exported for the link monitor.

## Interface

Parameters:
- `DATA_WIDTH`, 8, width of each lane word.
- `DEPTH`, 4, entries per lane FIFO; must be a power of two, at least 2.

Ports (one clock; reset is synchronous and active-high):
- `clk_f`  input  1  Receive word clock; all state updates on its rising edge.
- `reset`  input  1  Synchronous, active-high reset.
- `data_rx0..data_rx3`  input  DATA_WIDTH  Lane words from the demux stage.
- `valid_rx0..valid_rx3`  input  1  Lane word qualifiers; one word per asserted cycle.
- `ready_out`  input  1  Consumer can accept `data_out` this cycle.
- `data_out`  output  DATA_WIDTH  Merged output word (registered).
- `valid_out`  output  1  `data_out` holds a valid word (registered).
- `lane_out`  output  2  Source lane of `data_out` (registered).
- `fifo_full`  output  4  Bit N set when lane N FIFO holds DEPTH entries.
- `fifo_empty`  output  4  Bit N set when lane N FIFO holds 0 entries.
- `overflow`  output  4  Sticky; bit N set when a lane N word was dropped.

## Operation

- Per lane: circular buffer of DEPTH entries, write pointer, read pointer, and an occupancy count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Write: if `valid_rxN` is high and lane N is not full at the start of the cycle, the word is stored and the write pointer advances.
- Drop: if `valid_rxN` is high while lane N is full, the word is discarded and `overflow[N]` is set until reset. This holds even if lane N is popped in the same cycle, because full is sampled at the start of the cycle.
- Output register load: the output register loads when `valid_out` = 0 or `ready_out` = 1.
  - If any lane is non-empty, the arbiter grants one lane. The head word goes to `data_out`, the lane index to `lane_out`, and `valid_out` goes to 1. The granted lane's read pointer advances.
  - If no lane is non-empty, `valid_out` goes to 0, and `data_out`/`lane_out` hold their previous values.
- Hold: when `valid_out` = 1 and `ready_out` = 0, `data_out`, `lane_out` and `valid_out` hold, and no FIFO is read.
- Arbiter: round-robin with a 2-bit last-grant pointer. Search order is last+1, last+2, last+3, last (mod 4). The first non-empty lane wins, and last-grant is updated to the winner only on a grant.
- Same-cycle write and read of one lane: both take effect. The count is unchanged, except when full, where the write is dropped and the count decrements.
- `fifo_full`/`fifo_empty` are derived from the registered counts and reflect state after the last edge.
- Reset mid-operation: all FIFO contents are discarded, pointers and counts are cleared, overflow is cleared, and the output is invalidated. Inputs during the reset cycle are ignored.

## Timing

- Reset values:
  - `data_out` = 0, `valid_out` = 0, `lane_out` = 0.
  - `fifo_full` = 4'b0000, `fifo_empty` = 4'b1111, `overflow` = 4'b0000.
  - Last-grant = 3, so lane 0 wins the first arbitration.
- Latency: a word written into an empty lane at edge k appears on `data_out` with `valid_out` = 1 after edge k+1, provided the output register is free.
- Throughput: one word per cycle on the output while `ready_out` = 1 and any lane is non-empty. Aggregate input can reach 4 words/cycle, so sustained input above 1 word/cycle eventually overflows.
- Handshake: a transfer happens on any edge where `valid_out` = 1 and `ready_out` = 1. `data_out` must stay stable while `valid_out` = 1 and `ready_out` = 0.
- Flags update one edge after the causing write or read.

## Test plan

- Reset check: assert `reset` for 2 cycles while all valids are high -> all outputs at their reset values, `fifo_empty` = 4'b1111, and no word appears afterwards.
- Single-lane latency: lane 2 writes 0xA5 at edge k, `ready_out` = 1 -> after k+1 `data_out` = 0xA5, `lane_out` = 2, `valid_out` = 1; after k+2 `valid_out` = 0.
- Round-robin fairness: preload each lane with 2 words (lane N words 0xN0 and 0xN1), then hold `ready_out` = 1 -> output lane order is 0,1,2,3,0,1,2,3 with data 0x00,0x10,0x20,0x30,0x01,0x11,0x21,0x31.
- Backpressure: hold `ready_out` = 0 for 5 cycles with `valid_out` = 1 -> `data_out`/`lane_out` are stable, and with DEPTH = 4 lane 0 receiving 6 words gives `fifo_full[0]` = 1 and `overflow[0]` = 1. Release `ready_out` -> exactly 5 lane-0 words are delivered in order (1 in the output register + 4 buffered).
- Wrap-around and simultaneous read/write: stream 20 words into lane 1 at 1 word/cycle with `ready_out` = 1 -> all 20 words are delivered in order, the count never exceeds 2, and `overflow` stays 0.
- Mid-operation reset: reset while 3 lanes are non-empty and `valid_out` = 1 -> next cycle `valid_out` = 0, `fifo_empty` = 4'b1111, and the next word written after reset is output with lane 0 priority.

Source files
------------

// File: rtl/rx_lane_fifo_rr.sv
// rx_lane_fifo_rr: four per-lane receive FIFOs merged into one byte stream
// by a round-robin arbiter with a registered valid/ready output.
// Ports: clk_f, reset (sync, active-high); data_rx0..3/valid_rx0..3 lane
// words; ready_out/data_out/valid_out/lane_out merged output handshake;
// fifo_full/fifo_empty/overflow per-lane status for the link monitor.
module rx_lane_fifo_rr #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk_f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_rx0,
  input  logic [DATA_WIDTH-1:0] data_rx1,
  input  logic [DATA_WIDTH-1:0] data_rx2,
  input  logic [DATA_WIDTH-1:0] data_rx3,
  input  logic                  valid_rx0,
  input  logic                  valid_rx1,
  input  logic                  valid_rx2,
  input  logic                  valid_rx3,
  input  logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [1:0]            lane_out,
  output logic [3:0]            fifo_full,
  output logic [3:0]            fifo_empty,
  output logic [3:0]            overflow
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t      din [4];
  logic [3:0] vin;

  assign din[0] = data_rx0;
  assign din[1] = data_rx1;
  assign din[2] = data_rx2;
  assign din[3] = data_rx3;
  assign vin    = {valid_rx3, valid_rx2, valid_rx1, valid_rx0};

  word_t         mem_q  [4][DEPTH];
  word_t         mem_d  [4][DEPTH];
  logic [AW-1:0] wptr_q [4];
  logic [AW-1:0] wptr_d [4];
  logic [AW-1:0] rptr_q [4];
  logic [AW-1:0] rptr_d [4];
  logic [CW-1:0] cnt_q  [4];
  logic [CW-1:0] cnt_d  [4];
  logic [3:0]    ovf_q, ovf_d;
  logic [1:0]    last_q, last_d;
  word_t         dout_q, dout_d;
  logic          vout_q, vout_d;
  logic [1:0]    lane_q, lane_d;

  logic [3:0] full, empty, push, pop;
  logic       load, found;
  logic [1:0] gnt, idx;

  for (genvar i = 0; i < 4; i++) begin : g_flag
    assign full[i]  = (cnt_q[i] == FULL_CNT);
    assign empty[i] = (cnt_q[i] == '0);
  end

  // Output register is free when empty or being consumed this edge.
  assign load = !vout_q || ready_out;
  // Full is taken from the start of the cycle, so a pop never frees room
  // for a same-cycle write.
  assign push = vin & ~full;

  // Search last+1 .. last+4 (the last one wraps back to last itself).
  always_comb begin
    found = 1'b0;
    gnt   = last_q;
    idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && !empty[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pop[i] = load && found && (gnt == 2'(i));
    end
  end

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | (vin & full);
    last_d = last_q;
    dout_d = dout_q;
    vout_d = vout_q;
    lane_d = lane_q;
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_d[i][wptr_q[i]] = din[i];
        wptr_d[i] = wptr_q[i] + 1'b1;
      end
      if (pop[i]) begin
        rptr_d[i] = rptr_q[i] + 1'b1;
      end
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
    end
    if (load) begin
      if (found) begin
        dout_d = mem_q[gnt][rptr_q[gnt]];
        lane_d = gnt;
        vout_d = 1'b1;
        last_d = gnt;
      end else begin
        vout_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      ovf_q  <= '0;
      last_q <= 2'd3;
      dout_q <= '0;
      vout_q <= 1'b0;
      lane_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      last_q <= last_d;
      dout_q <= dout_d;
      vout_q <= vout_d;
      lane_q <= lane_d;
    end
  end

  assign data_out   = dout_q;
  assign valid_out  = vout_q;
  assign lane_out   = lane_q;
  assign fifo_full  = full;
  assign fifo_empty = empty;
  assign overflow   = ovf_q;

endmodule
